ram_write: RTL and testbench

RAM_WRITE -- requirements
Module: ram_write

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_write.sv | 138 +++++++++++++
 tb/tb_ram_write.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Constants shared between the AXI write and read masters of the RAM port:
// FSM state codes, AXI tie-off values and the AXI address width.
package ram_pkg;

  localparam int AXI_ADDR_W = 27;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ram_write.sv
// Single-byte AXI4 write master: one 64-bit beat with a one-hot strobe per request.
// Define RAM_WRITE_ERR_EN to flag non-OKAY responses on err and drop their write_signal pulse.
module ram_write
  import ram_pkg::*;
(
  input  logic                  clk_memory,
  input  logic                  reset,
  input  logic [20:0]           addr,
  input  logic [7:0]            data,
  input  logic                  en,
  output logic                  ready,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [AXI_ADDR_W-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic [3:0]            AWCACHE,
  output logic [2:0]            AWPROT,
  output logic                  AWLOCK,
  output logic [3:0]            AWQOS,
  output logic [3:0]            AWREGION,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [63:0]           WDATA,
  output logic [7:0]            WSTRB,
  output logic                  WLAST,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic [20:0]           write_addr,
  output logic [7:0]            write_data,
  output logic                  write_signal,
  output logic                  err
);

  logic [1:0]  state;
  logic        aw_done;
  logic        w_done;
  logic [20:0] cap_addr;
  logic [7:0]  cap_data;
  logic        aw_done_n;
  logic        w_done_n;
  logic        b_fire;
  logic        b_ok;

  assign AWLEN    = 8'd0;
  assign AWSIZE   = AXI_SIZE_8B;
  assign AWBURST  = AXI_BURST_INCR;
  assign AWCACHE  = AXI_CACHE_MOD;
  assign AWPROT   = 3'd0;
  assign AWLOCK   = 1'b0;
  assign AWQOS    = 4'd0;
  assign AWREGION = 4'd0;
  assign WLAST    = 1'b1;

  assign ready  = (state == ST_IDLE) || (state == ST_WAIT);
  assign BREADY = (state == ST_RESP);
  assign b_fire = BREADY && BVALID;

  // AW and W channels complete independently; either may finish first.
  assign aw_done_n = aw_done || (AWVALID && AWREADY);
  assign w_done_n  = w_done  || (WVALID && WREADY);

`ifdef RAM_WRITE_ERR_EN
  assign b_ok = (BRESP == AXI_RESP_OKAY);

  always_ff @(posedge clk_memory) begin
    if (reset)                err <= 1'b0;
    else if (b_fire && !b_ok) err <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^BRESP;
  assign b_ok         = 1'b1;
  assign err          = 1'b0;
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_memory) begin
    if (reset) begin
      state        <= ST_IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      cap_addr     <= '0;
      cap_data     <= '0;
      AWVALID      <= 1'b0;
      WVALID       <= 1'b0;
      AWADDR       <= '0;
      WDATA        <= '0;
      WSTRB        <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_signal <= 1'b0;
    end else begin
      write_signal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            cap_addr <= addr;
            cap_data <= data;
            AWADDR   <= {6'b0, addr[20:3], 3'b000};
            WDATA    <= {8{data}};
            WSTRB    <= 8'b1 << addr[2:0];
            AWVALID  <= 1'b1;
            WVALID   <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          aw_done <= aw_done_n;
          w_done  <= w_done_n;
          if (aw_done_n && w_done_n) state <= ST_RESP;
        end
        ST_RESP: begin
          if (BVALID) begin
            if (b_ok) begin
              write_addr <= cap_addr;
              write_data <= cap_data;
            end
            write_signal <= b_ok;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A held request must not start a second write.
          if (!en) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_write.sv
// Directed self-checking bench for ram_write; expectations follow RAM_WRITE_ERR_EN when defined.
module tb_ram_write;

  logic        clk_memory = 1'b0;
  logic        reset;
  logic [20:0] addr;
  logic [7:0]  data;
  logic        en;
  logic        ready;
  logic        AWVALID, AWREADY;
  logic [26:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic        AWLOCK;
  logic [3:0]  AWQOS, AWREGION;
  logic        WVALID, WREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic [20:0] write_addr;
  logic [7:0]  write_data;
  logic        write_signal;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;
  int aw_count = 0;
  int ws_count = 0;

  ram_write dut (
    .clk_memory(clk_memory), .reset(reset), .addr(addr), .data(data), .en(en), .ready(ready),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWLOCK(AWLOCK), .AWQOS(AWQOS),
    .AWREGION(AWREGION), .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .WLAST(WLAST), .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .write_addr(write_addr),
    .write_data(write_data), .write_signal(write_signal), .err(err)
  );

  always #5 clk_memory = ~clk_memory;

  always @(posedge clk_memory) begin
    if (AWVALID && AWREADY) aw_count++;
    if (write_signal)       ws_count++;
  end

  task automatic tick();
    @(posedge clk_memory);
    #1;
  endtask

  // Drives one request with slave READY/BVALID delays counted from the en rise.
  task automatic run_write(input logic [20:0] a, input logic [7:0] d, input int aw_dly,
                           input int w_dly, input int b_dly, input logic [1:0] resp,
                           input int obs_at, output int cycles, output int first_bready,
                           output int bready_cycles, output logic ready_low_ok,
                           output logic [2:0] obs);
    int   cnt;
    logic hs;
    cnt = 0; hs = 1'b0; first_bready = -1; bready_cycles = 0; ready_low_ok = 1'b1; obs = '0;
    addr = a; data = d; en = 1'b1; BRESP = resp;
    while (!hs && cnt < 100) begin
      if (cnt == 1) begin
        addr = ~a;
        data = ~d;
      end
      AWREADY = (cnt >= aw_dly);
      WREADY  = (cnt >= w_dly);
      BVALID  = (cnt >= b_dly);
      if (cnt == obs_at) obs = {AWVALID, WVALID, BREADY};
      if (cnt > 0 && ready !== 1'b0) ready_low_ok = 1'b0;
      if (BREADY === 1'b1) begin
        bready_cycles++;
        if (first_bready < 0) first_bready = cnt;
      end
      hs = BVALID && BREADY;
      tick();
      cnt++;
    end
    BVALID = 1'b0;
    BRESP  = 2'b00;
    cycles = cnt;
    n_total++;
    if (!hs) $display("FAIL b_handshake_timeout: got no handshake after %0d cycles, want one", cnt);
    else n_pass++;
  endtask

  task automatic finish_write();
    en = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [29:0] tie;
    reset = 1'b1; en = 1'b0; addr = '0; data = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tie = {AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT, AWLOCK, AWQOS, AWREGION, WLAST};
    n_total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready); else n_pass++;
    n_total++; if ({AWVALID, WVALID, BREADY} !== 3'b000) $display("FAIL rst_valids: got %b want 000", {AWVALID, WVALID, BREADY}); else n_pass++;
    n_total++; if ({write_signal, err} !== 2'b00) $display("FAIL rst_pulse_err: got %b want 00", {write_signal, err}); else n_pass++;
    n_total++; if ({AWADDR, WSTRB, WDATA, write_addr, write_data} !== '0) $display("FAIL rst_regs: got nonzero, want zero"); else n_pass++;
    n_total++; if (tie !== {8'd0, 3'b011, 2'b01, 4'b0011, 3'd0, 1'b0, 4'd0, 4'd0, 1'b1}) $display("FAIL tie_offs: got %h want %h", tie, {8'd0, 3'b011, 2'b01, 4'b0011, 3'd0, 1'b0, 4'd0, 4'd0, 1'b1}); else n_pass++;
  endtask

  task automatic test_basic();
    int cyc, fb, bc, ws0; logic rl; logic [2:0] ob;
    ws0 = ws_count;
    run_write(21'h01234B, 8'hA5, 0, 0, 0, 2'b00, 1, cyc, fb, bc, rl, ob);
    n_total++; if (cyc !== 3) $display("FAIL basic_latency: got %0d want 3", cyc); else n_pass++;
    n_total++; if (ob !== 3'b110) $display("FAIL basic_valids_in_addr: got %b want 110", ob); else n_pass++;
    n_total++; if (AWADDR !== 27'h0012348) $display("FAIL basic_awaddr: got %h want 0012348", AWADDR); else n_pass++;
    n_total++; if (WSTRB !== 8'h08) $display("FAIL basic_wstrb: got %h want 08", WSTRB); else n_pass++;
    n_total++; if (WDATA !== 64'hA5A5A5A5A5A5A5A5) $display("FAIL basic_wdata: got %h want a5a5a5a5a5a5a5a5", WDATA); else n_pass++;
    n_total++; if ({ready, write_signal} !== 2'b11) $display("FAIL basic_ready_pulse: got %b want 11", {ready, write_signal}); else n_pass++;
    n_total++; if ({write_addr, write_data} !== {21'h01234B, 8'hA5}) $display("FAIL basic_wr_out: got %h/%h want 01234b/a5", write_addr, write_data); else n_pass++;
    finish_write();
    n_total++; if (write_signal !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", write_signal); else n_pass++;
    n_total++; if (ws_count - ws0 !== 1) $display("FAIL basic_pulse_count: got %0d want 1", ws_count - ws0); else n_pass++;
  endtask

  task automatic test_lanes();
    int cyc, fb, bc; logic rl; logic [2:0] ob;
    run_write(21'h1FFFFF, 8'h3C, 0, 0, 0, 2'b00, 1, cyc, fb, bc, rl, ob);
    n_total++; if ({AWADDR, WSTRB} !== {27'h01FFFF8, 8'h80}) $display("FAIL top_lane: got %h/%h want 01ffff8/80", AWADDR, WSTRB); else n_pass++;
    n_total++; if (WDATA !== 64'h3C3C3C3C3C3C3C3C) $display("FAIL top_wdata: got %h want 3c3c3c3c3c3c3c3c", WDATA); else n_pass++;
    finish_write();
    run_write(21'h000000, 8'h5A, 0, 0, 0, 2'b00, 1, cyc, fb, bc, rl, ob);
    n_total++; if ({AWADDR, WSTRB} !== {27'h0, 8'h01}) $display("FAIL low_lane: got %h/%h want 0000000/01", AWADDR, WSTRB); else n_pass++;
    finish_write();
  endtask

  task automatic test_w_before_aw();
    int cyc, fb, bc, ws0; logic rl; logic [2:0] ob;
    ws0 = ws_count;
    run_write(21'h0ABCD2, 8'h11, 5, 3, 0, 2'b00, 4, cyc, fb, bc, rl, ob);
    n_total++; if (ob !== 3'b100) $display("FAIL wfirst_valids: got %b want 100", ob); else n_pass++;
    n_total++; if (fb !== 6) $display("FAIL wfirst_resp_entry: got cycle %0d want 6", fb); else n_pass++;
    n_total++; if (cyc !== 7) $display("FAIL wfirst_latency: got %0d want 7", cyc); else n_pass++;
    finish_write();
    n_total++; if (ws_count - ws0 !== 1) $display("FAIL wfirst_pulse_count: got %0d want 1", ws_count - ws0); else n_pass++;
  endtask

  task automatic test_b_delay();
    int cyc, fb, bc, ws0; logic rl; logic [2:0] ob;
    ws0 = ws_count;
    run_write(21'h000105, 8'h77, 0, 0, 7, 2'b00, 0, cyc, fb, bc, rl, ob);
    n_total++; if ({fb, bc} !== {32'd2, 32'd6}) $display("FAIL bdelay_bready: got first %0d count %0d want 2/6", fb, bc); else n_pass++;
    n_total++; if (rl !== 1'b1) $display("FAIL bdelay_ready_low: got %b want 1", rl); else n_pass++;
    n_total++; if (cyc !== 8) $display("FAIL bdelay_latency: got %0d want 8", cyc); else n_pass++;
    finish_write();
    n_total++; if (ws_count - ws0 !== 1) $display("FAIL bdelay_pulse_count: got %0d want 1", ws_count - ws0); else n_pass++;
  endtask

  task automatic test_held_en();
    int cyc, fb, bc, aw0, ws0; logic rl, held_ready; logic [2:0] ob;
    run_write(21'h000F00, 8'hC3, 0, 0, 0, 2'b00, 0, cyc, fb, bc, rl, ob);
    aw0 = aw_count; ws0 = ws_count; held_ready = 1'b1;
    tick();
    ws0 = ws0 + 1;
    for (int i = 0; i < 20; i++) begin
      if (ready !== 1'b1) held_ready = 1'b0;
      tick();
    end
    n_total++; if (aw_count - aw0 !== 0) $display("FAIL held_aw_count: got %0d want 0", aw_count - aw0); else n_pass++;
    n_total++; if (ws_count - ws0 !== 0) $display("FAIL held_pulse_count: got %0d want 0", ws_count - ws0); else n_pass++;
    n_total++; if (held_ready !== 1'b1) $display("FAIL held_ready: got %b want 1", held_ready); else n_pass++;
    finish_write();
    aw0 = aw_count;
    run_write(21'h000F01, 8'h3D, 0, 0, 0, 2'b00, 0, cyc, fb, bc, rl, ob);
    n_total++; if (aw_count - aw0 !== 1) $display("FAIL second_aw_count: got %0d want 1", aw_count - aw0); else n_pass++;
    n_total++; if (write_data !== 8'h3D) $display("FAIL second_data: got %h want 3d", write_data); else n_pass++;
    finish_write();
  endtask

  task automatic test_reset_mid();
    int cyc, fb, bc; logic rl; logic [2:0] ob;
    addr = 21'h012340; data = 8'h99; en = 1'b1; AWREADY = 1'b0; WREADY = 1'b0;
    tick(); tick();
    n_total++; if ({AWVALID, WVALID} !== 2'b11) $display("FAIL mid_in_addr: got %b want 11", {AWVALID, WVALID}); else n_pass++;
    reset = 1'b1; en = 1'b0;
    tick();
    reset = 1'b0;
    n_total++; if ({AWVALID, WVALID, BREADY} !== 3'b000) $display("FAIL mid_valids: got %b want 000", {AWVALID, WVALID, BREADY}); else n_pass++;
    n_total++; if ({ready, err} !== 2'b10) $display("FAIL mid_ready_err: got %b want 10", {ready, err}); else n_pass++;
    run_write(21'h012341, 8'h42, 0, 0, 0, 2'b00, 0, cyc, fb, bc, rl, ob);
    n_total++; if ({cyc, write_addr, write_signal} !== {32'd3, 21'h012341, 1'b1}) $display("FAIL mid_recover: got %0d/%h/%b want 3/012341/1", cyc, write_addr, write_signal); else n_pass++;
    finish_write();
  endtask

  task automatic test_bresp_err();
    int cyc, fb, bc, ws0; logic rl; logic [2:0] ob;
    ws0 = ws_count;
    run_write(21'h000222, 8'hEE, 0, 0, 0, 2'b10, 0, cyc, fb, bc, rl, ob);
    finish_write();
`ifdef RAM_WRITE_ERR_EN
    n_total++; if (err !== 1'b1) $display("FAIL slverr_err: got %b want 1", err); else n_pass++;
    n_total++; if (ws_count - ws0 !== 0) $display("FAIL slverr_pulse: got %0d want 0", ws_count - ws0); else n_pass++;
    run_write(21'h000223, 8'hEF, 0, 0, 0, 2'b00, 0, cyc, fb, bc, rl, ob);
    finish_write();
    n_total++; if (err !== 1'b1) $display("FAIL slverr_sticky: got %b want 1", err); else n_pass++;
`else
    n_total++; if (err !== 1'b0) $display("FAIL slverr_err: got %b want 0", err); else n_pass++;
    n_total++; if (ws_count - ws0 !== 1) $display("FAIL slverr_pulse: got %0d want 1", ws_count - ws0); else n_pass++;
    n_total++; if (write_data !== 8'hEE) $display("FAIL slverr_data: got %h want ee", write_data); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_w_before_aw();
    test_b_delay();
    test_held_en();
    test_reset_mid();
    test_bresp_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
